// File: rtl/chdr_packet_demux_if.sv
// CHDR demux bus: 64-bit CHDR ingress stream plus
// NUM_OUTPUTS payload streams carrying {header, timestamp} in tuser.
interface chdr_packet_demux_if #(
  parameter int NUM_OUTPUTS = 2
);
  logic [63:0]               i_tdata;
  logic                      i_tlast;
  logic                      i_tvalid;
  logic                      i_tready;
  logic [NUM_OUTPUTS*64-1:0]  o_tdata;
  logic [NUM_OUTPUTS*128-1:0] o_tuser;
  logic [NUM_OUTPUTS-1:0]     o_tlast;
  logic [NUM_OUTPUTS-1:0]     o_tvalid;
  logic [NUM_OUTPUTS-1:0]     o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid,
    output i_tready,
    output o_tdata, o_tuser, o_tlast, o_tvalid,
    input  o_tready
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid,
    input  i_tready,
    input  o_tdata, o_tuser, o_tlast, o_tvalid,
    output o_tready
  );
endinterface

// File: rtl/chdr_packet_demux.sv
// CHDR header/timestamp stripper and SID-steered payload demux.
// Define CHDR_PACKET_DEMUX_STATS_EN to build the drop_count counter.
module chdr_packet_demux #(
  parameter int NUM_OUTPUTS = 2,
  parameter int SEL_LSB     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  chdr_packet_demux_if.slave bus,
  output logic [15:0]        drop_count
);

  localparam int SW =
    (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [15:0] NUM_O = 16'(NUM_OUTPUTS);

  typedef enum logic [1:0] {
    ST_HDR, ST_TIME, ST_PAY, ST_DROP
  } state_t;

  typedef struct packed {
    logic [63:0]   data;
    logic          last;
    logic [SW-1:0] sel;
    logic [127:0]  user;
  } beat_t;

  state_t      state, state_nxt;
  logic [63:0] hdr, ts;
  beat_t       m_q, s_q, in_beat;
  logic        m_vld, s_vld;
  logic        rdy, fire, pop, push;
  logic        hdr_ld, ts_ld, drop_inc;
  logic [15:0] dst_in, dst_hdr;

  function automatic logic [SW-1:0] sel_of(
    input logic [15:0] dst
  );
    return (NUM_OUTPUTS == 1) ? '0 : dst[SW-1:0];
  endfunction

  // The whole destination field above SEL_LSB must
  // address a real port, not just the select bits.
  assign dst_in  = bus.i_tdata[15:0] >> SEL_LSB;
  assign dst_hdr = hdr[15:0] >> SEL_LSB;

  assign rdy = reset &
    ((state == ST_PAY) ? ~s_vld : 1'b1);
  assign bus.i_tready = rdy;
  assign fire = bus.i_tvalid & rdy;
  assign pop  = m_vld & bus.o_tready[m_q.sel];

  always_comb begin
    in_beat.data = bus.i_tdata;
    in_beat.last = bus.i_tlast;
    in_beat.sel  = sel_of(dst_hdr);
    in_beat.user = {hdr, hdr[61] ? ts : 64'h0};
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    hdr_ld    = 1'b0;
    ts_ld     = 1'b0;
    drop_inc  = 1'b0;
    unique case (state)
      ST_HDR: if (fire) begin
        hdr_ld = 1'b1;
        if (bus.i_tlast) begin
          drop_inc = 1'b1;
        end else if (dst_in >= NUM_O) begin
          drop_inc  = 1'b1;
          state_nxt = ST_DROP;
        end else if (bus.i_tdata[61]) begin
          state_nxt = ST_TIME;
        end else begin
          state_nxt = ST_PAY;
        end
      end
      ST_TIME: if (fire) begin
        ts_ld = 1'b1;
        if (bus.i_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = ST_HDR;
        end else begin
          state_nxt = ST_PAY;
        end
      end
      ST_PAY: if (fire) begin
        push = 1'b1;
        if (bus.i_tlast) state_nxt = ST_HDR;
      end
      ST_DROP: begin
        if (fire && bus.i_tlast) state_nxt = ST_HDR;
      end
      default: state_nxt = ST_HDR;
    endcase
    // A flush mid-packet must still eat the packet tail.
    if (clear) begin
      push     = 1'b0;
      hdr_ld   = 1'b0;
      ts_ld    = 1'b0;
      drop_inc = 1'b0;
      if (fire ? bus.i_tlast : (state == ST_HDR))
        state_nxt = ST_HDR;
      else
        state_nxt = ST_DROP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_HDR;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr <= '0;
      ts  <= '0;
    end else begin
      if (hdr_ld) hdr <= bus.i_tdata;
      if (ts_ld)  ts  <= bus.i_tdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (clear) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (s_vld) begin
      if (pop) begin
        m_q   <= s_q;
        s_vld <= 1'b0;
      end
    end else if (push) begin
      if (!m_vld || pop) begin
        m_q   <= in_beat;
        m_vld <= 1'b1;
      end else begin
        s_q   <= in_beat;
        s_vld <= 1'b1;
      end
    end else if (pop) begin
      m_vld <= 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      bus.o_tvalid[i] = m_vld & (m_q.sel == SW'(i));
      bus.o_tlast[i]  = m_vld & m_q.last &
                        (m_q.sel == SW'(i));
      bus.o_tdata[i*64 +: 64]   = m_q.data;
      bus.o_tuser[i*128 +: 128] = m_q.user;
    end
  end

`ifdef CHDR_PACKET_DEMUX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_count <= '0;
    else if (clear)
      drop_count <= '0;
    else if (drop_inc && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`else
  logic stats_unused;
  assign stats_unused = drop_inc;
  assign drop_count   = 16'h0;
`endif

endmodule

// File: tb/tb_chdr_packet_demux.sv
// Randomized bench for chdr_packet_demux with a packet-level
// reference model and a per-cycle output compare process.
module tb_chdr_packet_demux;
  localparam int N       = 2;
  localparam int SEL_LSB = 0;

  typedef struct {
    logic [63:0]  data;
    logic         last;
    logic [127:0] user;
  } beat_t;

  typedef struct {
    int           port;
    logic [63:0]  data;
    logic         last;
    logic [127:0] user;
    int           cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] drop_count;

  chdr_packet_demux_if #(.NUM_OUTPUTS(N)) bus();

  chdr_packet_demux #(
    .NUM_OUTPUTS(N),
    .SEL_LSB(SEL_LSB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .bus(bus),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  beat_t       exp_q[N][$];
  obs_t        log_q[$];
  logic [63:0] cur_pay[$];
  int          model_drops = 0;

  bit          rand_rdy = 1'b0;
  logic [N-1:0] rdy_fixed = '1;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               name, act, req);
    end
  endtask

  function automatic logic [15:0] exp_dc();
`ifdef CHDR_PACKET_DEMUX_STATS_EN
    return (model_drops > 65535) ? 16'hFFFF
                                 : 16'(model_drops);
`else
    return 16'h0;
`endif
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Packet-level model: a packet with no payload or an
  // out-of-range destination is one drop; otherwise every
  // payload word goes to port dst with the packet's tuser.
  function automatic void model_packet(
    input logic [63:0] hdr, input logic [63:0] ts);
    int    dst;
    beat_t b;
    dst = int'(hdr[15:0]) >> SEL_LSB;
    if (cur_pay.size() == 0 || dst >= N) begin
      model_drops++;
      return;
    end
    for (int i = 0; i < cur_pay.size(); i++) begin
      b.data = cur_pay[i];
      b.last = (i == cur_pay.size() - 1);
      b.user = {hdr, hdr[61] ? ts : 64'h0};
      exp_q[dst].push_back(b);
    end
  endfunction

  // Output driver: random or fixed ready, changed after edges.
  initial begin
    bus.o_tready = '1;
    forever begin
      @(posedge clk);
      #1;
      bus.o_tready = rand_rdy ? N'($urandom) : rdy_fixed;
    end
  end

  // Compare process: every negedge, every output port.
  logic [N-1:0] prev_stall;
  logic [192:0] saved[N];
  logic [192:0] cur;
  beat_t        e;
  initial begin
    prev_stall = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = '0;
      end else begin
        if ($countones(bus.o_tvalid) > 1) begin
          checks++;
          errors++;
          $display("FAIL onehot: o_tvalid=%b required <=1 bit",
                   bus.o_tvalid);
        end
        for (int i = 0; i < N; i++) begin
          cur = {bus.o_tdata[i*64 +: 64], bus.o_tlast[i],
                 bus.o_tuser[i*128 +: 128]};
          if (bus.o_tvalid[i]) begin
            if (prev_stall[i])
              chk($sformatf("stable%0d", i), cur, saved[i]);
            if (bus.o_tready[i]) begin
              log_q.push_back('{i, cur[192:129], cur[128],
                                cur[127:0], cyc});
              if (exp_q[i].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat%0d: got %0h required none",
                         i, cur[192:129]);
              end else begin
                e = exp_q[i].pop_front();
                chk($sformatf("beat%0d", i), cur,
                    {e.data, e.last, e.user});
              end
            end
          end
          prev_stall[i] = bus.o_tvalid[i] & ~bus.o_tready[i];
          saved[i] = cur;
        end
      end
    end
  end

  task automatic send_word(input logic [63:0] d,
                           input logic l,
                           output int acc);
    int n;
    n = 0;
    acc = -1;
    bus.i_tdata  = d;
    bus.i_tlast  = l;
    bus.i_tvalid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.i_tready) begin
        acc = cyc;
        break;
      end
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no i_tready required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.i_tvalid = 1'b0;
  endtask

  task automatic gap(input bit en);
    if (en && $urandom_range(0, 4) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_packet(input logic [63:0] hdr,
                             input logic [63:0] ts,
                             input int npay,
                             input logic [63:0] base,
                             input bit gaps,
                             output int h,
                             output int span);
    int a;
    cur_pay.delete();
    for (int i = 0; i < npay; i++)
      cur_pay.push_back(base != 0 ? base + 64'(i)
                                  : {$urandom, $urandom});
    model_packet(hdr, ts);
    gap(gaps);
    send_word(hdr, (npay == 0) && !hdr[61], h);
    a = h;
    if (hdr[61]) begin
      gap(gaps);
      send_word(ts, npay == 0, a);
    end
    for (int i = 0; i < npay; i++) begin
      gap(gaps);
      send_word(cur_pay[i], i == npay - 1, a);
    end
    span = a - h;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (pending() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 256'(pending()), 256'd0);
    @(negedge clk);
    @(negedge clk);
    chk("drain_tvalid", 256'(bus.o_tvalid), 256'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, sp, a, kind, np;
    logic [63:0] hdr, ts;
    logic [15:0] dst;

    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 256'(bus.o_tvalid), 256'd0);
    chk("rst_tready", 256'(bus.i_tready), 256'd0);
    chk("rst_tdata",  256'(bus.o_tdata),  256'd0);
    chk("rst_tuser",  256'(bus.o_tuser),  256'd0);
    chk("rst_tlast",  256'(bus.o_tlast),  256'd0);
    chk("rst_drop",   256'(drop_count),   256'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Plain packet to output 1.
    log_q.delete();
    hdr = 64'h0001_0018_0000_0001;
    send_packet(hdr, 64'h0, 3, 64'hA0, 1'b0, h, sp);
    wait_drain();
    chk("t1_count", 256'(log_q.size()), 256'd3);
    for (int k = 0; k < log_q.size() && k < 3; k++) begin
      chk("t1_port", 256'(log_q[k].port), 256'd1);
      chk("t1_data", 256'(log_q[k].data), 256'(64'hA0 + k));
      chk("t1_last", 256'(log_q[k].last), 256'(k == 2));
      chk("t1_user", 256'(log_q[k].user),
          {128'h0, 64'h0001_0018_0000_0001, 64'h0});
      chk("t1_cyc", 256'(log_q[k].cyc - h), 256'(k + 2));
    end

    // Timestamped packet to output 0.
    log_q.delete();
    hdr = 64'h2002_0020_0000_0000;
    send_packet(hdr, 64'h1234, 2, 64'hB0, 1'b0, h, sp);
    wait_drain();
    chk("t2_count", 256'(log_q.size()), 256'd2);
    for (int k = 0; k < log_q.size() && k < 2; k++) begin
      chk("t2_port", 256'(log_q[k].port), 256'd0);
      chk("t2_data", 256'(log_q[k].data), 256'(64'hB0 + k));
      chk("t2_ts", 256'(log_q[k].user[63:0]), 256'h1234);
      chk("t2_cyc", 256'(log_q[k].cyc - h), 256'(k + 3));
    end

    // Out-of-range destination, then header-only packet.
    log_q.delete();
    hdr = 64'h0003_0010_0000_0003;
    send_packet(hdr, 64'h0, 2, 64'hC0, 1'b0, h, sp);
    chk("t3_span", 256'(sp), 256'd2);
    chk("t3_model", 256'(model_drops), 256'd1);
    chk("t3_drop", 256'(drop_count), 256'(exp_dc()));
    hdr = 64'h0004_0008_0000_0001;
    send_packet(hdr, 64'h0, 0, 64'h0, 1'b0, h, sp);
    chk("t4_model", 256'(model_drops), 256'd2);
    chk("t4_drop", 256'(drop_count), 256'(exp_dc()));
    wait_drain();
    chk("t3_noout", 256'(log_q.size()), 256'd0);

    // Randomized traffic with 50% output ready.
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      kind = $urandom_range(0, 9);
      np   = $urandom_range(1, 6);
      dst  = 16'(p % 2);
      if (kind == 0)
        dst = 16'($urandom_range(2, 65535));
      else if (kind == 1)
        np = 0;
      hdr = {2'($urandom), 1'($urandom), 1'($urandom),
             12'(p), 16'($urandom), 16'($urandom), dst};
      ts  = {$urandom, $urandom};
      send_packet(hdr, ts, np, 64'h0, 1'b1, h, sp);
    end
    wait_drain();
    rand_rdy = 1'b0;
    rdy_fixed = '1;
    @(posedge clk);
    #1;
    chk("rand_drop", 256'(drop_count), 256'(exp_dc()));

    // Flush on beat 2 of a 5-beat packet.
    log_q.delete();
    hdr = 64'h0005_0028_0000_0001;
    e.data = 64'hD0;
    e.last = 1'b0;
    e.user = {hdr, 64'h0};
    exp_q[1].push_back(e);
    send_word(hdr, 1'b0, a);
    send_word(64'hD0, 1'b0, a);
    clear = 1'b1;
    send_word(64'hD1, 1'b0, a);
    clear = 1'b0;
    model_drops = 0;
    send_word(64'hD2, 1'b0, a);
    send_word(64'hD3, 1'b0, a);
    send_word(64'hD4, 1'b1, a);
    chk("clr_drop", 256'(drop_count), 256'd0);
    hdr = 64'h0006_0018_0000_0000;
    send_packet(hdr, 64'h0, 3, 64'hE0, 1'b0, h, sp);
    wait_drain();
    chk("clr_count", 256'(log_q.size()), 256'd4);
    if (log_q.size() == 4) begin
      chk("clr_first", 256'(log_q[0].data), 256'hD0);
      chk("clr_next", 256'(log_q[3].data), 256'hE2);
    end

    // Reset in the middle of a stalled payload.
    rdy_fixed = '0;
    @(posedge clk);
    #1;
    send_word(64'h0007_0020_0000_0000, 1'b0, a);
    send_word(64'hF0, 1'b0, a);
    send_word(64'hF1, 1'b0, a);
    @(negedge clk);
    chk("pre_rst_tvalid", 256'(bus.o_tvalid), 256'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_tvalid", 256'(bus.o_tvalid), 256'd0);
    chk("mid_rst_tready", 256'(bus.i_tready), 256'd0);
    chk("mid_rst_drop", 256'(drop_count), 256'd0);
    model_drops = 0;
    #3;
    reset = 1'b1;
    rdy_fixed = '1;
    @(posedge clk);
    #1;
    log_q.delete();
    hdr = 64'h2008_0018_0000_0001;
    send_packet(hdr, 64'h55AA, 2, 64'h90, 1'b0, h, sp);
    wait_drain();
    chk("rst_next_count", 256'(log_q.size()), 256'd2);
    if (log_q.size() == 2)
      chk("rst_next_user", 256'(log_q[0].user),
          {128'h0, 64'h2008_0018_0000_0001, 64'h55AA});
    chk("final_drop", 256'(drop_count), 256'(exp_dc()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
